// File: rtl/fpu_addsub_sched.sv
// -----------------------------------------------------------------------------
// fpu_addsub_sched
//
// Shares one fixed-latency FP32 add/sub datapath between two requesters.
// Requests are arbitrated round-robin and at most one operation is issued per
// cycle. A shadow pipeline of {valid, src, tag} runs alongside the datapath so
// that each result on dp_R can be tagged with its origin when it emerges.
// Results are collected in a response FIFO. Issue is credit-limited so the FIFO
// can never overflow, because the datapath itself cannot be stalled.
//
// Ports
//   clk, arst_n                 clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready     issue handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op     FP32 operands and operation (0 = add, 1 = sub)
//   reqN_tag                    requester tag, returned with the result
//   dp_valid, dp_a, dp_b, dp_op operation issued to the datapath this cycle
//   dp_R                        datapath result, LAT edges after issue
//   rsp_valid / rsp_ready       response handshake (FIFO head)
//   rsp_R, rsp_src, rsp_tag     result, originating requester and tag
// -----------------------------------------------------------------------------
module fpu_addsub_sched #(
   parameter int LAT        = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 2
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic             req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             dp_valid,
   output logic [31:0]      dp_a,
   output logic [31:0]      dp_b,
   output logic             dp_op,
   input  logic [31:0]      dp_R,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_R,
   output logic             rsp_src,
   output logic [TAG_W-1:0] rsp_tag
);

   localparam int DATA_W = 32;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);

   logic             last_grant;
   logic             gnt_src;
   logic             any_req;
   logic             can_issue;
   logic             issue;
   logic [TAG_W-1:0] iss_tag;

   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   credit_used;

   logic             push;
   logic             pop;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Shadow pipeline, index i holds datapath stage i+1.
   logic             sh_vld_p [LAT];
   logic             sh_src_p [LAT];
   logic [TAG_W-1:0] sh_tag_p [LAT];

   logic [DATA_W-1:0] mem_r   [FIFO_DEPTH];
   logic              mem_src [FIFO_DEPTH];
   logic [TAG_W-1:0]  mem_tag [FIFO_DEPTH];

   // ---- issue stage: credit check and round-robin arbitration ----
   // Credit uses registered counts only, so a pop frees its slot one cycle later.
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign can_issue   = (credit_used < DEPTH_SUM);

   always_comb begin
      gnt_src = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_src = ~last_grant;
      end else if (req1_valid) begin
         gnt_src = 1'b1;
      end
   end

   assign any_req    = req0_valid | req1_valid;
   // Outputs are forced low while reset is asserted.
   assign issue      = arst_n & can_issue & any_req;
   assign req0_ready = issue & ~gnt_src;
   assign req1_ready = issue & gnt_src;
   assign dp_valid   = issue;
   assign iss_tag    = gnt_src ? req1_tag : req0_tag;

   // Idle cycles present requester 0's operands.
   always_comb begin
      dp_a  = '0;
      dp_b  = '0;
      dp_op = 1'b0;
      if (arst_n) begin
         if (issue && gnt_src) begin
            dp_a  = req1_a;
            dp_b  = req1_b;
            dp_op = req1_op;
         end else begin
            dp_a  = req0_a;
            dp_b  = req0_b;
            dp_op = req0_op;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         last_grant <= 1'b1;
      end else if (issue) begin
         last_grant <= gnt_src;
      end
   end

   // ---- shadow stages 1..LAT: track source/tag alongside the datapath ----
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < LAT; i++) sh_vld_p[i] <= 1'b0;
      end else begin
         sh_vld_p[0] <= issue;
         for (int i = 1; i < LAT; i++) sh_vld_p[i] <= sh_vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      sh_src_p[0] <= gnt_src;
      sh_tag_p[0] <= iss_tag;
      for (int i = 1; i < LAT; i++) begin
         sh_src_p[i] <= sh_src_p[i-1];
         sh_tag_p[i] <= sh_tag_p[i-1];
      end
   end

   // The last shadow stage is valid exactly when dp_R carries a live result.
   assign push = sh_vld_p[LAT-1];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         inflight <= '0;
      end else if (issue && !push) begin
         inflight <= inflight + CNT_W'(1);
      end else if (!issue && push) begin
         inflight <= inflight - CNT_W'(1);
      end
   end

   // ---- response FIFO stage ----
   assign rsp_valid = (fifo_count != '0);
   assign pop       = rsp_valid & rsp_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr]   <= dp_R;
         mem_src[wr_ptr] <= sh_src_p[LAT-1];
         mem_tag[wr_ptr] <= sh_tag_p[LAT-1];
      end
   end

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop) begin
            fifo_count <= fifo_count + CNT_W'(1);
         end else if (!push && pop) begin
            fifo_count <= fifo_count - CNT_W'(1);
         end
      end
   end

   // Head is shown only when valid so uninitialised storage never leaks out.
   assign rsp_R   = rsp_valid ? mem_r[rd_ptr]   : '0;
   assign rsp_src = rsp_valid ? mem_src[rd_ptr] : 1'b0;
   assign rsp_tag = rsp_valid ? mem_tag[rd_ptr] : '0;

   // Credit makes this unreachable; a hit means the credit logic is broken.
   push_into_full : assert property (@(posedge clk) disable iff (!arst_n)
                                     !(push && (fifo_count == DEPTH_CNT)));

endmodule
